apb_requester: RTL and testbench
================================

# apb_requester

Parametrised APB4 requester engine that turns a valid/ready command stream into a single APB transfer at a time and returns a valid/ready response. It drives the APB SETUP/ACCESS phases, absorbs completer wait states, enforces APB4 rules on strobes and signal stability, and aborts transfers that exceed a configurable wait-state budget. It sits between an internal command source (bus bridge, CSR sequencer) and the APB requester-side signals.

## Interface
- ADDR_WIDTH, 32, width of paddr and cmd_addr
- DATA_WIDTH, 32, width of pwdata/prdata/cmd_wdata/rsp_rdata; must be 8, 16 or 32; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before abort; 0 disables the timeout

Ports:
- pclk  in  1  APB clock; all state updates on the rising edge
- presetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine can accept a command
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
- rsp_slverr  out  1  completer error or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- paddr, pprot, pwrite, pwdata, pstrb  out  ADDR_WIDTH, 3, 1, DATA_WIDTH, DATA_WIDTH/8  APB request fields
- pnse  out  1  tied 0 (secure/non-secure extension unused)
- psel, penable  out  1, 1  APB phase controls
- pready, prdata, pslverr  in  1, DATA_WIDTH, 1  APB completion inputs

## Operation
- States: IDLE, SETUP, ACCESS, RESP. Reset state IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register all cmd fields into APB outputs, go SETUP. pstrb forced to 0 when cmd_write=0.
- SETUP: psel=1, penable=0; unconditionally go ACCESS.
- ACCESS: psel=1, penable=1; wait counter increments each cycle. On pready=1: capture pslverr; capture prdata only for reads (else rsp_rdata=0); rsp_timeout=0; go RESP.
- Timeout (TIMEOUT_CYCLES>0): if pready=0 in the TIMEOUT_CYCLES-th ACCESS cycle, abort: rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, go RESP. pready=1 in that same cycle completes normally (completion wins).
- RESP: psel=penable=0; rsp_valid=1 with fields stable until rsp_valid&rsp_ready, then IDLE.
- paddr, pprot, pwrite, pwdata, pstrb held stable from SETUP through the last ACCESS cycle; outside a transfer they keep their last value.
- cmd_ready=0 in SETUP, ACCESS, RESP; one transfer outstanding, no pipelining.
- Counter width $clog2(TIMEOUT_CYCLES+1); cleared on entry to SETUP; never wraps (saturates at TIMEOUT_CYCLES).
- Reset asserted mid-operation: immediately all outputs to reset values, state IDLE, in-flight command and response discarded.

## Timing
- Reset values: psel, penable, pwrite, pnse, rsp_valid, rsp_slverr, rsp_timeout = 0; paddr, pprot, pwdata, pstrb, rsp_rdata = 0; cmd_ready=1 (IDLE, combinational from state).
- Accept edge E0 -> psel=1 after E0 (SETUP) -> penable=1 after E1 (ACCESS) -> pready sampled at E2 and later.
- Zero-wait completer: rsp_valid=1 after E2; psel/penable=0 in the same cycle; minimum command-to-response latency 3 cycles.
- Each pready=0 ACCESS cycle adds one cycle of latency.
- rsp_ready high on the first RESP cycle: IDLE next cycle; next accept possible one cycle later; minimum 4 cycles per transfer.
- rsp_ready ignored outside RESP; cmd_valid ignored outside IDLE.

## Test plan
- Reset: hold presetn=0 with random inputs -> all APB outputs 0, rsp_valid=0, cmd_ready=1; release -> no activity until cmd_valid.
- Zero-wait write addr=0x0000_0010, wdata=0xDEAD_BEEF, strb=0xF, prot=3'b010 -> psel one cycle before penable, fields stable, rsp_valid 3 cycles after accept, rsp_slverr=0, rsp_rdata=0.
- Read with 5 wait states, prdata=0x1234_5678, pslverr=1 on completion, strb input 0xF -> pstrb=0 throughout, ACCESS lasts 6 cycles, rsp_rdata=0x1234_5678, rsp_slverr=1, rsp_timeout=0.
- TIMEOUT_CYCLES=4, pready stuck 0 -> exactly 4 ACCESS cycles, then psel=0, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0; repeat with pready=1 in 4th cycle -> normal completion.
- Response backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and fields stable, cmd_ready=0, no new psel; then back-to-back commands achieve 4-cycle spacing.
- presetn pulsed low during ACCESS -> psel/penable drop asynchronously, no rsp_valid afterwards, next command completes normally.

Source files
------------

// File: rtl/apb_requester.sv
// APB4 requester: accepts one command at a time over valid/ready, runs the
// APB SETUP/ACCESS handshake, and returns a response.
// Ports: pclk/presetn (async active-low reset), cmd_* command channel,
// rsp_* response channel, p* APB requester-side signals.
module apb_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pnse,
  output logic                    psel,
  output logic                    penable,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int SW = DATA_WIDTH / 8;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW =
    TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    TO_EN ? CW'(TIMEOUT_CYCLES) : '0;
  // Counter value seen during the last permitted ACCESS cycle.
  localparam logic [CW-1:0] CNT_LAST =
    TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [2:0]            pprot_q, pprot_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  slverr_q, slverr_d;
  logic                  tmo_q, tmo_d;
  logic                  tmo_hit;

  assign tmo_hit = TO_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pprot_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pprot_q  <= pprot_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (cmd_valid) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (pready || tmo_hit) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    penable   = (state_q == S_ACCESS);
    rsp_valid = (state_q == S_RESP);
  end

  // Request fields load only on accept, so they stay put through the
  // transfer and keep their last value afterwards. Response fields load
  // only on leaving ACCESS, so they stay stable through RESP.
  always_comb begin
    paddr_d  = paddr_q;
    pprot_d  = pprot_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    tmo_d    = tmo_q;
    if (state_q == S_IDLE && cmd_valid) begin
      paddr_d  = cmd_addr;
      pprot_d  = cmd_prot;
      pwrite_d = cmd_write;
      pwdata_d = cmd_wdata;
      pstrb_d  = cmd_write ? cmd_strb : '0;
      cnt_d    = '0;
    end
    if (state_q == S_ACCESS) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      // A completion in the final budget cycle beats the timeout.
      if (pready) begin
        rdata_d  = pwrite_q ? '0 : prdata;
        slverr_d = pslverr;
        tmo_d    = 1'b0;
      end else if (tmo_hit) begin
        rdata_d  = '0;
        slverr_d = 1'b1;
        tmo_d    = 1'b1;
      end
    end
  end

  assign paddr       = paddr_q;
  assign pprot       = pprot_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pnse        = 1'b0;
  assign rsp_rdata   = rdata_q;
  assign rsp_slverr  = slverr_q;
  assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: randomized transfers against a
// transfer-level reference model, plus directed reset/timeout scenarios.
module tb_apb_requester;

  localparam int TO = 6;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        cmd_write;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr, rsp_timeout;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic        pwrite, pnse, psel, penable;
  logic [3:0]  pstrb;
  logic        pready, pslverr;

  int          wait_n = 0;
  logic        err_v = 1'b0;
  logic [31:0] rd_v = '0;
  int          acc_cnt;
  int          cyc_g = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  apb_requester #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pprot(pprot), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pnse(pnse),
    .psel(psel), .penable(penable),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc_g++;

  // Completer: asserts pready in ACCESS cycle index wait_n; drives the
  // inverse of the completion data while waiting to catch early capture.
  assign pready  = psel && penable && (acc_cnt == wait_n);
  assign prdata  = pready ? rd_v : ~rd_v;
  assign pslverr = pready ? err_v : ~err_v;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  typedef struct {
    logic        rdy;
    int          setup;
    int          acc;
    int          lat;
    int          unst;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    logic        post_v;
    logic        post_r;
    int          acc_cyc;
  } res_t;

  typedef struct {
    int          acc;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  function automatic exp_t model(input logic wr, input int w,
                                 input logic e, input logic [31:0] d);
    exp_t m;
    m.to    = (TO > 0) && (w >= TO);
    m.acc   = m.to ? TO : w + 1;
    m.lat   = m.acc + 2;
    m.err   = m.to | e;
    m.rdata = (m.to || wr) ? 32'h0 : d;
    return m;
  endfunction

  // Stimulus driver; entered and left at a negedge. Returns observations.
  task automatic do_xfer(
    input logic [31:0] a, input logic wr, input logic [31:0] wd,
    input logic [3:0] sb, input logic [2:0] pr, input int w,
    input logic e, input logic [31:0] d, input int rdly,
    input logic busy_cmd, output res_t r);
    logic [3:0] es;
    es = wr ? sb : 4'h0;
    r = '{default: 0};
    wait_n = w; err_v = e; rd_v = d;
    cmd_addr = a; cmd_write = wr; cmd_wdata = wd;
    cmd_strb = sb; cmd_prot = pr; cmd_valid = 1'b1;
    r.rdy = cmd_ready;
    r.acc_cyc = cyc_g;
    @(negedge pclk);
    r.lat = 1;
    while (!rsp_valid && r.lat < 200) begin
      cmd_valid = busy_cmd;
      cmd_addr = $urandom; cmd_wdata = $urandom;
      cmd_write = 1'($urandom); cmd_strb = 4'($urandom);
      cmd_prot = 3'($urandom);
      rsp_ready = 1'($urandom);
      if (psel && !penable) r.setup++;
      if (psel && penable) r.acc++;
      if (psel && (paddr !== a || pprot !== pr || pwrite !== wr ||
                   pwdata !== wd || pstrb !== es)) r.unst++;
      if (cmd_ready) r.unst++;
      @(negedge pclk);
      r.lat++;
    end
    r.rdata = rsp_rdata; r.err = rsp_slverr; r.to = rsp_timeout;
    if (psel || penable || !rsp_valid) r.unst++;
    for (int i = 0; i < rdly; i++) begin
      rsp_ready = 1'b0;
      if (psel || cmd_ready || !rsp_valid ||
          rsp_rdata !== r.rdata || rsp_slverr !== r.err ||
          rsp_timeout !== r.to) r.unst++;
      @(negedge pclk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    r.post_v = rsp_valid;
    r.post_r = cmd_ready;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'($urandom); cmd_addr = $urandom;
      cmd_wdata = $urandom; cmd_write = 1'($urandom);
      cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
      rsp_ready = 1'($urandom);
      @(negedge pclk);
      n_cmp++;
      if ({psel, penable, pwrite, pnse, rsp_valid, rsp_slverr,
           rsp_timeout, cmd_ready} !== 8'b0000_0001 ||
          paddr !== 0 || pprot !== 0 || pwdata !== 0 ||
          pstrb !== 0 || rsp_rdata !== 0) begin
        n_bad++;
        $display("FAIL reset_vals cyc %0d: psel=%b pen=%b rv=%b cr=%b paddr=%h",
                 i, psel, penable, rsp_valid, cmd_ready, paddr);
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    presetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      n_cmp++;
      if (psel !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_idle: psel=%b rsp_valid=%b cmd_ready=%b want 0 0 1",
                 psel, rsp_valid, cmd_ready);
      end
    end
  endtask

  task automatic test_zero_wait();
    res_t r;
    do_xfer(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 1'b0,
            32'h5555_AAAA, 0, 1'b0, r);
    n_cmp++;
    if (r.rdy !== 1'b1 || r.setup != 1 || r.acc != 1 || r.lat != 3) begin
      n_bad++;
      $display("FAIL zw_timing: rdy=%b setup=%0d acc=%0d lat=%0d want 1 1 1 3",
               r.rdy, r.setup, r.acc, r.lat);
    end
    n_cmp++;
    if (r.rdata !== 32'h0 || r.err !== 1'b0 || r.to !== 1'b0) begin
      n_bad++;
      $display("FAIL zw_rsp: rdata=%h err=%b to=%b want 0 0 0",
               r.rdata, r.err, r.to);
    end
    n_cmp++;
    if (r.unst != 0 || r.post_v !== 1'b0 || r.post_r !== 1'b1) begin
      n_bad++;
      $display("FAIL zw_stable: unst=%0d post_v=%b post_r=%b want 0 0 1",
               r.unst, r.post_v, r.post_r);
    end
    n_cmp++;
    if (paddr !== 32'h10 || pwdata !== 32'hDEAD_BEEF || pprot !== 3'b010) begin
      n_bad++;
      $display("FAIL zw_hold: paddr=%h pwdata=%h pprot=%b want 10 deadbeef 010",
               paddr, pwdata, pprot);
    end
  endtask

  task automatic test_wait_read();
    res_t r;
    do_xfer(32'h0000_0200, 1'b0, 32'hFFFF_0000, 4'hF, 3'b001, 5, 1'b1,
            32'h1234_5678, 0, 1'b0, r);
    n_cmp++;
    if (r.acc != 6 || r.lat != 8 || r.unst != 0) begin
      n_bad++;
      $display("FAIL wr_timing: acc=%0d lat=%0d unst=%0d want 6 8 0",
               r.acc, r.lat, r.unst);
    end
    n_cmp++;
    if (r.rdata !== 32'h1234_5678 || r.err !== 1'b1 || r.to !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_rsp: rdata=%h err=%b to=%b want 12345678 1 0",
               r.rdata, r.err, r.to);
    end
  endtask

  task automatic test_timeout();
    res_t r;
    do_xfer(32'h40, 1'b0, 32'h0, 4'h3, 3'b000, 1000, 1'b0,
            32'hCAFE_F00D, 0, 1'b0, r);
    n_cmp++;
    if (r.acc != TO || r.lat != TO + 2 || r.unst != 0) begin
      n_bad++;
      $display("FAIL to_stuck_timing: acc=%0d lat=%0d unst=%0d want %0d %0d 0",
               r.acc, r.lat, r.unst, TO, TO + 2);
    end
    n_cmp++;
    if (r.rdata !== 32'h0 || r.err !== 1'b1 || r.to !== 1'b1) begin
      n_bad++;
      $display("FAIL to_stuck_rsp: rdata=%h err=%b to=%b want 0 1 1",
               r.rdata, r.err, r.to);
    end
    do_xfer(32'h44, 1'b0, 32'h0, 4'h3, 3'b000, TO - 1, 1'b0,
            32'hCAFE_F00D, 0, 1'b0, r);
    n_cmp++;
    if (r.acc != TO || r.rdata !== 32'hCAFE_F00D ||
        r.err !== 1'b0 || r.to !== 1'b0) begin
      n_bad++;
      $display("FAIL to_edge_win: acc=%0d rdata=%h err=%b to=%b want %0d cafef00d 0 0",
               r.acc, r.rdata, r.err, r.to, TO);
    end
  endtask

  task automatic test_back_to_back();
    res_t r;
    int   prev;
    do_xfer(32'h80, 1'b1, 32'h1111_2222, 4'h5, 3'b111, 2, 1'b0,
            32'h0, 10, 1'b1, r);
    n_cmp++;
    if (r.unst != 0 || r.acc != 3 || r.post_v !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_stable: unst=%0d acc=%0d post_v=%b want 0 3 0",
               r.unst, r.acc, r.post_v);
    end
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      do_xfer(32'h100 + 32'(i * 4), 1'(i), $urandom, 4'hF, 3'b000, 0,
              1'b0, $urandom, 0, 1'b0, r);
      if (prev >= 0) begin
        n_cmp++;
        if (r.acc_cyc - prev != 4 || r.rdy !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_spacing: gap=%0d rdy=%b want 4 1",
                   r.acc_cyc - prev, r.rdy);
        end
      end
      prev = r.acc_cyc;
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    exp_t m;
    int   seen;
    wait_n = 1000;
    cmd_addr = 32'hABC0; cmd_write = 1'b1; cmd_wdata = 32'h7;
    cmd_strb = 4'h1; cmd_prot = 3'b100; cmd_valid = 1'b1;
    @(negedge pclk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    n_cmp++;
    if (psel !== 1'b0 || penable !== 1'b0 || paddr !== 32'h0 ||
        cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_async: psel=%b pen=%b paddr=%h cr=%b want 0 0 0 1",
               psel, penable, paddr, cmd_ready);
    end
    @(negedge pclk);
    presetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      if (rsp_valid || psel) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL rst_mid_quiet: active cycles=%0d want 0", seen);
    end
    m = model(1'b0, 1, 1'b0, 32'h0BAD_CAFE);
    do_xfer(32'h20, 1'b0, 32'h0, 4'hF, 3'b000, 1, 1'b0,
            32'h0BAD_CAFE, 0, 1'b0, r);
    n_cmp++;
    if (r.acc != m.acc || r.rdata !== m.rdata || r.err !== m.err) begin
      n_bad++;
      $display("FAIL rst_mid_next: acc=%0d rdata=%h err=%b want %0d %h %b",
               r.acc, r.rdata, r.err, m.acc, m.rdata, m.err);
    end
  endtask

  task automatic test_random();
    res_t        r;
    exp_t        m;
    logic [31:0] a, wd, d;
    logic        wr, e;
    logic [3:0]  sb;
    logic [2:0]  pr;
    int          w;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; wd = $urandom; d = $urandom;
      wr = 1'($urandom); e = 1'($urandom);
      sb = 4'($urandom); pr = 3'($urandom);
      w = $urandom_range(0, TO + 2);
      m = model(wr, w, e, d);
      do_xfer(a, wr, wd, sb, pr, w, e, d, $urandom_range(0, 3),
              1'($urandom), r);
      n_cmp++;
      if (r.acc != m.acc || r.lat != m.lat || r.setup != 1) begin
        n_bad++;
        $display("FAIL rnd%0d_timing: acc=%0d lat=%0d setup=%0d want %0d %0d 1",
                 i, r.acc, r.lat, r.setup, m.acc, m.lat);
      end
      n_cmp++;
      if (r.rdata !== m.rdata || r.err !== m.err || r.to !== m.to) begin
        n_bad++;
        $display("FAIL rnd%0d_rsp: rdata=%h err=%b to=%b want %h %b %b",
                 i, r.rdata, r.err, r.to, m.rdata, m.err, m.to);
      end
      n_cmp++;
      if (r.unst != 0 || r.rdy !== 1'b1 || r.post_v !== 1'b0 ||
          r.post_r !== 1'b1) begin
        n_bad++;
        $display("FAIL rnd%0d_proto: unst=%0d rdy=%b post_v=%b post_r=%b want 0 1 0 1",
                 i, r.unst, r.rdy, r.post_v, r.post_r);
      end
    end
  endtask

  initial begin
    presetn = 1'b0;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0;
    test_reset();
    test_zero_wait();
    test_wait_read();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
